mem_bus_arbiter: RTL



---
 rtl/mem_bus_arb_pkg.sv | 24 ++
 rtl/mem_bus_arb_pick.sv | 46 ++++
 rtl/mem_bus_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mem_bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arb_pkg
// Brief    : Shared types and constants for the two-master memory bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_arb_pkg;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arb_pick
// Brief    : Combinational winner selection (lock owner, then tie rule).
//            MEM_BUS_ARB_RR_EN selects round-robin ties, else CPU wins ties.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arb_pick
    import mem_bus_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dma_req,
    input  owner_t owner,
`ifdef MEM_BUS_ARB_RR_EN
    input  logic   last_served,
`endif
    output logic   cpu_win,
    output logic   dma_win
);

    always_comb begin
        cpu_win = 1'b0;
        dma_win = 1'b0;
        // An owner that stopped requesting falls through to normal arbitration.
        if ((owner == OWN_CPU) && cpu_req) begin
            cpu_win = 1'b1;
        end else if ((owner == OWN_DMA) && dma_req) begin
            dma_win = 1'b1;
        end else if (cpu_req && dma_req) begin
`ifdef MEM_BUS_ARB_RR_EN
            if (last_served == REQ_CPU) begin
                dma_win = 1'b1;
            end else begin
                cpu_win = 1'b1;
            end
`else
            cpu_win = 1'b1;
`endif
        end else begin
            cpu_win = cpu_req;
            dma_win = dma_req;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Shares one memory port between CPU and DMA with lock and
//            one-cycle read return. MEM_BUS_ARB_RR_EN enables round-robin ties.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          cpu_req,
    input  logic          cpu_lock,
    input  logic          cpu_rw,
    input  logic [AW-1:0] cpu_ad,
    input  logic [DW-1:0] cpu_wd,
    output logic          cpu_gnt,
    output logic [DW-1:0] cpu_rd,
    output logic          cpu_rvalid,

    input  logic          dma_req,
    input  logic          dma_lock,
    input  logic          dma_rw,
    input  logic [AW-1:0] dma_ad,
    input  logic [DW-1:0] dma_wd,
    output logic          dma_gnt,
    output logic [DW-1:0] dma_rd,
    output logic          dma_rvalid,

    output logic          mem_rw,
    output logic [AW-1:0] mem_ad,
    output logic [DW-1:0] mem_dout,
    input  logic [DW-1:0] mem_din
);

    logic    w_cpu_win;
    logic    w_dma_win;
    logic    w_cpu_gnt;
    logic    w_dma_gnt;
    logic    w_gnt_any;
    logic    w_gnt_id;
    logic    w_gnt_rw;
    logic    w_gnt_lock;
    owner_t  r_owner;
    rd_tag_t r_tag;

`ifdef MEM_BUS_ARB_RR_EN
    logic    r_last_served;
`endif

    mem_bus_arb_pick u_pick (
        .cpu_req     (cpu_req),
        .dma_req     (dma_req),
        .owner       (r_owner),
`ifdef MEM_BUS_ARB_RR_EN
        .last_served (r_last_served),
`endif
        .cpu_win     (w_cpu_win),
        .dma_win     (w_dma_win)
    );

    // Grants are forced low while reset is held, whatever the requests.
    assign w_cpu_gnt  = rst_n & w_cpu_win;
    assign w_dma_gnt  = rst_n & w_dma_win;
    assign w_gnt_any  = w_cpu_gnt | w_dma_gnt;
    assign w_gnt_id   = w_dma_gnt ? REQ_DMA : REQ_CPU;
    assign w_gnt_rw   = w_dma_gnt ? dma_rw   : cpu_rw;
    assign w_gnt_lock = w_dma_gnt ? dma_lock : cpu_lock;

    assign cpu_gnt = w_cpu_gnt;
    assign dma_gnt = w_dma_gnt;

    always_comb begin
        mem_rw   = 1'b1;
        mem_ad   = '0;
        mem_dout = '0;
        if (w_cpu_gnt) begin
            mem_rw   = cpu_rw;
            mem_ad   = cpu_ad;
            mem_dout = cpu_wd;
        end else if (w_dma_gnt) begin
            mem_rw   = dma_rw;
            mem_ad   = dma_ad;
            mem_dout = dma_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner     <= OWN_NONE;
            r_tag.valid <= 1'b0;
            r_tag.id    <= REQ_CPU;
        end else begin
            r_tag.valid <= w_gnt_any & w_gnt_rw;
            r_tag.id    <= w_gnt_id;
            if (w_gnt_any && w_gnt_lock) begin
                r_owner <= (w_gnt_id == REQ_DMA) ? OWN_DMA : OWN_CPU;
            end else begin
                r_owner <= OWN_NONE;
            end
        end
    end

`ifdef MEM_BUS_ARB_RR_EN
    // Reset to DMA so the CPU takes the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_served <= REQ_DMA;
        end else if (w_gnt_any) begin
            r_last_served <= w_gnt_id;
        end
    end
`endif

    assign cpu_rd     = mem_din;
    assign dma_rd     = mem_din;
    assign cpu_rvalid = rst_n & r_tag.valid & (r_tag.id == REQ_CPU);
    assign dma_rvalid = rst_n & r_tag.valid & (r_tag.id == REQ_DMA);

endmodule
`default_nettype wire
